// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result FIFO toward writeback,
// architectural flag register and condition evaluation.
module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [31:0] in_res,
  input  logic        in_o,
  input  logic        in_s,
  input  logic        in_c,
  input  logic [3:0]  in_rd,
  input  logic        in_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [3:0]  out_rd,
  output logic        out_wen,
  output logic [3:0]  flags,
  input  logic [3:0]  cond,
  output logic        cond_true
);

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wen;
  } ent_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] flg_q, flg_d;

  logic push, pop;
  logic z_new;
  logic is_arith, is_shift, is_logic;
  ent_t new_ent;

  // Handshakes: in_ready depends on registered count only.
  always_comb begin
    in_ready  = (cnt_q < FULL);
    out_valid = (cnt_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Incoming entry and opcode classification.
  always_comb begin
    new_ent.res = in_res;
    new_ent.rd  = in_rd;
    new_ent.wen = in_wen;
    z_new       = (in_res == 32'd0);
    is_logic    = in_op[4];
    is_shift    = (in_op == 5'b01000) ||
                  (in_op == 5'b01001);
    is_arith    = (in_op == 5'b00000) ||
                  (in_op == 5'b00001) ||
                  (in_op == 5'b00011) ||
                  (in_op == 5'b00100) ||
                  (in_op == 5'b00101) ||
                  (in_op == 5'b00110);
  end

  // FIFO next state; head always holds the oldest entry.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      cnt_d  = 2'd0;
      head_d = '0;
      tail_d = '0;
    end else if (push && pop) begin
      head_d = new_ent;
    end else if (push) begin
      if (cnt_q == 2'd0) head_d = new_ent;
      else               tail_d = new_ent;
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      head_d = tail_q;
      tail_d = '0;
      cnt_d  = cnt_q - 2'd1;
    end
  end

  // Flags {O,S,C,Z} follow accepted, non-flushed pushes.
  always_comb begin
    flg_d = flg_q;
    if (push && !flush) begin
      unique case (1'b1)
        is_arith: flg_d = {in_o, in_s, in_c, z_new};
        is_shift: flg_d = {1'b0, in_res[31], in_c, z_new};
        is_logic: flg_d = {flg_q[3], in_res[31],
                           flg_q[1], z_new};
        default:  flg_d = flg_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      flg_q  <= 4'b0000;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      flg_q  <= flg_d;
    end
  end

  // Head fields, forced to zero when nothing is valid.
  always_comb begin
    out_res = out_valid ? head_q.res : 32'd0;
    out_rd  = out_valid ? head_q.rd  : 4'd0;
    out_wen = out_valid & head_q.wen;
    flags   = flg_q;
  end

  // Condition evaluation against registered flags.
  always_comb begin
    logic fo, fs, fc, fz;
    {fo, fs, fc, fz} = flg_q;
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = fz;
      4'd2:    cond_true = !fz;
      4'd3:    cond_true = fc;
      4'd4:    cond_true = !fc;
      4'd5:    cond_true = fs;
      4'd6:    cond_true = !fs;
      4'd7:    cond_true = fo;
      4'd8:    cond_true = !fo;
      4'd9:    cond_true = (fs == fo);
      4'd10:   cond_true = (fs != fo);
      4'd11:   cond_true = !fz && (fs == fo);
      4'd12:   cond_true = fz || (fs != fo);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a
// queue scoreboard checked by a separate monitor.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_res;
  logic        in_o, in_s, in_c;
  logic [3:0]  in_rd;
  logic        in_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_rd;
  logic        out_wen;
  logic [3:0]  flags;
  logic [3:0]  cond;
  logic        cond_true;

  int total = 0;
  int bad   = 0;
  logic [36:0] sb[$];

  alu_result_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_res(in_res),
    .in_o(in_o), .in_s(in_s), .in_c(in_c),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd),
    .out_wen(out_wen), .flags(flags),
    .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [36:0] act,
                     input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [31:0] res,
                       input logic o, s, c,
                       input logic [3:0] rd,
                       input logic wen,
                       input logic acc);
    in_valid = 1'b1;
    in_op = op; in_res = res;
    in_o = o; in_s = s; in_c = c;
    in_rd = rd; in_wen = wen;
    chk("in_ready", 37'(in_ready), 37'(acc));
    if (acc) sb.push_back({res, rd, wen});
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op = '0; in_res = '0;
    in_o = 0; in_s = 0; in_c = 0;
    in_rd = '0; in_wen = 0;
  endtask

  task automatic chk_cond(input logic [3:0] cc,
                          input logic exp);
    cond = cc;
    #1;
    chk($sformatf("cond%0d", cc),
        37'(cond_true), 37'(exp));
  endtask

  // Monitor: pops expectations on each handshake.
  logic        hold_v = 1'b0;
  logic [36:0] hold_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v && out_valid)
        chk("stable", {out_res, out_rd, out_wen},
            hold_e);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 37'(1), 37'(0));
        end else begin
          chk("pop", {out_res, out_rd, out_wen},
              sb.pop_front());
        end
      end
      if (!out_valid)
        chk("idle_zero", {out_res, out_rd, out_wen},
            37'(0));
      hold_v = out_valid && !out_ready &&
               !flush;
      hold_e = {out_res, out_rd, out_wen};
    end else begin
      hold_v = 1'b0;
    end
  end

  // Directed condition table at flags 4'b0110.
  logic [3:0] ctab_c[10] =
    '{4'd3, 4'd4, 4'd5, 4'd7, 4'd8,
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
  logic       ctab_e[10] =
    '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
      1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    rst = 1; flush = 0; out_ready = 0;
    cond = 0;
    idle();
    tick(); tick();
    rst = 0;
    chk("rst_valid", 37'(out_valid), 37'(0));
    chk("rst_ready", 37'(in_ready), 37'(1));
    chk("rst_flags", 37'(flags), 37'(0));
    chk("rst_res", 37'(out_res), 37'(0));
    chk_cond(4'd0, 1'b1);
    chk_cond(4'd2, 1'b1);
    chk_cond(4'd1, 1'b0);

    // Single push, 1-cycle latency.
    drive(5'b00000, 32'd0, 0, 0, 1,
          4'd3, 1, 1);
    idle();
    chk("lat_valid", 37'(out_valid), 37'(1));
    chk("lat_flags", 37'(flags), 37'(4'b0011));
    chk_cond(4'd1, 1'b1);
    out_ready = 1;
    tick();
    chk("drain1", 37'(out_valid), 37'(0));

    // Fill to two, third refused.
    out_ready = 0;
    drive(5'b00000, 32'd5, 0, 0, 0,
          4'd1, 1, 1);
    drive(5'b00000, 32'd7, 0, 0, 0,
          4'd2, 0, 1);
    drive(5'b00000, 32'd0, 0, 0, 1,
          4'd4, 1, 0);
    idle();
    chk("full_ready", 37'(in_ready), 37'(0));
    chk("refused_flags", 37'(flags), 37'(0));
    out_ready = 1;
    tick(); tick();
    chk("drain2", 37'(out_valid), 37'(0));

    // Logic op keeps C and O.
    drive(5'b00000, 32'd1, 1, 0, 1,
          4'd5, 1, 1);
    chk("f1010", 37'(flags), 37'(4'b1010));
    drive(5'b10001, 32'h80000000, 0, 0, 0,
          4'd6, 1, 1);
    chk("f1110", 37'(flags), 37'(4'b1110));

    // Shift clears O.
    drive(5'b00000, 32'd0, 1, 1, 1,
          4'd7, 0, 1);
    chk("f1111", 37'(flags), 37'(4'b1111));
    drive(5'b01001, 32'd0, 1, 1, 0,
          4'd8, 1, 1);
    chk("f0001", 37'(flags), 37'(4'b0001));
    drive(5'b01000, 32'h80000004, 1, 0, 1,
          4'd9, 1, 1);
    chk("f0110", 37'(flags), 37'(4'b0110));
    drive(5'b00010, 32'd0, 1, 1, 0,
          4'd10, 1, 1);
    idle();
    chk("other_keep", 37'(flags), 37'(4'b0110));
    for (int i = 0; i < 10; i++)
      chk_cond(ctab_c[i], ctab_e[i]);
    cond = 0;
    tick();
    chk("drain3", 37'(out_valid), 37'(0));

    // Flush at count=1 drops a concurrent push.
    out_ready = 0;
    drive(5'b00000, 32'd9, 1, 1, 0,
          4'd11, 1, 1);
    chk("f1100", 37'(flags), 37'(4'b1100));
    flush = 1;
    in_valid = 1; in_op = 5'b00000;
    in_res = 0; in_o = 0; in_s = 0; in_c = 1;
    tick();
    flush = 0;
    idle();
    sb.delete();
    chk("fl1_valid", 37'(out_valid), 37'(0));
    chk("fl1_ready", 37'(in_ready), 37'(1));
    chk("fl1_flags", 37'(flags), 37'(4'b1100));

    // Flush at count=2.
    drive(5'b00000, 32'd10, 1, 1, 0,
          4'd12, 1, 1);
    drive(5'b00000, 32'd11, 1, 1, 0,
          4'd13, 0, 1);
    flush = 1;
    in_valid = 1; in_op = 5'b00000;
    in_res = 0; in_o = 0; in_s = 0; in_c = 1;
    tick();
    flush = 0;
    idle();
    sb.delete();
    chk("fl2_valid", 37'(out_valid), 37'(0));
    chk("fl2_ready", 37'(in_ready), 37'(1));
    chk("fl2_flags", 37'(flags), 37'(4'b1100));

    // Reset with one entry and a lost push.
    drive(5'b00000, 32'd0, 1, 1, 1,
          4'd14, 1, 1);
    chk("pre_rst", 37'(flags), 37'(4'b1111));
    rst = 1;
    in_valid = 1; in_op = 5'b00000;
    in_res = 32'd5; in_rd = 4'd15; in_wen = 1;
    tick();
    rst = 0;
    idle();
    sb.delete();
    chk("r2_valid", 37'(out_valid), 37'(0));
    chk("r2_flags", 37'(flags), 37'(0));
    chk("r2_res", 37'(out_res), 37'(0));
    chk("r2_ready", 37'(in_ready), 37'(1));

    out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("sb_empty", 37'(sb.size()), 37'(0));
    tick();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL use parameter DEPTH, default 2, result-buffer entries; only value 2 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of buffered results.
REQ-005 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result.
REQ-007 SHALL have port in_op  input  5  ALU opcode of the result.
REQ-008 SHALL have port in_res  input  32  ALU RES.
REQ-009 SHALL have ports in_o, in_s, in_c  input  1 each  ALU O, S, C.
REQ-010 SHALL have port in_rd  input  4  destination register index.
REQ-011 SHALL have port in_wen  input  1  register write requested.
REQ-012 SHALL have port out_valid  output  1  head entry valid toward writeback.
REQ-013 SHALL have port out_ready  input  1  writeback consumes the head entry.
REQ-014 SHALL have ports out_res (32), out_rd (4), out_wen (1)  output  head entry fields.
REQ-015 SHALL have port flags  output  4  architectural {O,S,C,Z}, bit 3 = O.
REQ-016 SHALL have port cond  input  4  condition code to evaluate.
REQ-017 SHALL have port cond_true  output  1  cond evaluated against flags.

Function
REQ-018 SHALL accept a result on a cycle when in_valid=1 and in_ready=1 (push); SHALL pop on a cycle when out_valid=1 and out_ready=1.
REQ-019 SHALL drive in_ready = (count < 2) from registered count only; no combinational path from out_ready to in_ready.
REQ-020 SHALL be a 2-entry FIFO: a push into an empty buffer gives out_valid=1 next cycle, 1-cycle latency.
REQ-021 SHALL keep count unchanged and pass the oldest entry out on a simultaneous push and pop at count=1.
REQ-022 SHALL hold out_res, out_rd, out_wen stable while out_valid=1 and out_ready=0.
REQ-023 SHALL compute Z internally as (in_res == 0) at push time; no ALU Z input exists.
REQ-024 SHALL update flags at push time by opcode class:
  - arith 00000, 00001, 00011, 00100, 00101, 00110: O=in_o, S=in_s, C=in_c, Z=local.
  - shift 01000, 01001: S=in_res[31], Z=local, C=in_c, O=0.
  - logic 1xxxx: S=in_res[31], Z=local; C and O unchanged.
  - all other opcodes: flags unchanged, result still buffered.
REQ-025 SHALL make flag updates visible on flags the cycle after push, regardless of pop timing.
REQ-026 SHALL evaluate cond_true combinationally from registered flags:
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O.
  - 9 S==O; 10 S!=O; 11 !Z&(S==O); 12 Z|(S!=O); 13-15 false.
REQ-027 SHALL, on flush=1, set count=0 and out_valid=0 next cycle, and discard any push that cycle including its flag update; flags SHALL otherwise be retained.
REQ-028 SHALL drive out_res, out_rd, out_wen to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set count=0, buffer contents=0, out_valid=0, out_res=0, out_rd=0, out_wen=0, flags=4'b0000; in_ready=1 the next cycle.
REQ-030 SHALL give rst priority over flush, push and pop; a push during rst is lost.
REQ-031 SHALL produce cond_true=1 for cond=0 and for cond=2 after reset, because flags=0.

Verification
REQ-032 Push op=00000, res=0, o=0, s=0, c=1 into empty -> next cycle out_valid=1, out_res=0, flags=4'b0011, cond=1 gives cond_true=1.
REQ-033 Push 3 back-to-back with out_ready=0 -> third refused (in_ready=0 after 2), out_ready=1 then pops entries 1, 2 in order.
REQ-034 After flags=4'b1010, push op=10001, res=32'h80000000 -> flags=4'b1110 (C, O kept; S=1, Z=0).
REQ-035 Push op=01001, res=0, c=0 over flags=4'b1111 -> flags=4'b0001.
REQ-036 Flush with 2 entries plus a simultaneous push of op=00000, res=0 -> out_valid=0, in_ready=1 next cycle, flags unchanged.
REQ-037 rst asserted with count=1, flags=4'b1111 -> next cycle out_valid=0, flags=0, out_res=0.
